// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for a layered-free (flooding) LDPC decoder: sequences
// load, check-node, variable-node and syndrome-check phases until convergence or MAX_ITER.
module ldpc_iter_ctrl #(
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 4,
  parameter int CNU_CYC  = 2,
  parameter int VNU_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              syn_valid,
  input  logic              syn_zero,
  output logic              load_en,
  output logic              cnu_en,
  output logic              vnu_en,
  output logic              chk_en,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              success
);

  localparam int MAX_CYC = (CNU_CYC > VNU_CYC) ? CNU_CYC : VNU_CYC;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [PH_W-1:0]   CNU_LAST  = PH_W'(CNU_CYC - 1);
  localparam logic [PH_W-1:0]   VNU_LAST  = PH_W'(VNU_CYC - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CNU,
    S_VNU,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [PH_W-1:0] phase;

  // Phase counter counts down from CYC-1; a phase ends when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      success  <= 1'b0;
      phase    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            iter_cnt <= '0;
            success  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state   <= S_IDLE;
            success <= 1'b0;
          end else begin
            state <= S_CNU;
            phase <= CNU_LAST;
          end
        end
        S_CNU: begin
          if (abort) begin
            state   <= S_IDLE;
            success <= 1'b0;
          end else if (phase == '0) begin
            state <= S_VNU;
            phase <= VNU_LAST;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        S_VNU: begin
          if (abort) begin
            state   <= S_IDLE;
            success <= 1'b0;
          end else if (phase == '0) begin
            state <= S_CHECK;
            phase <= '0;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        // Abort outranks a syndrome result arriving in the same cycle.
        S_CHECK: begin
          if (abort) begin
            state   <= S_IDLE;
            success <= 1'b0;
          end else if (syn_valid) begin
            if (syn_zero) begin
              state   <= S_DONE;
              success <= 1'b1;
            end else if (iter_cnt == LAST_ITER) begin
              state   <= S_DONE;
              success <= 1'b0;
            end else begin
              state    <= S_CNU;
              phase    <= CNU_LAST;
              iter_cnt <= iter_cnt + ITER_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode from the state register only; rst forces them low at once.
  assign load_en = (state == S_LOAD)  && !rst;
  assign cnu_en  = (state == S_CNU)   && !rst;
  assign vnu_en  = (state == S_VNU)   && !rst;
  assign chk_en  = (state == S_CHECK) && !rst;
  assign done    = (state == S_DONE)  && !rst;
  assign busy    = (state != S_IDLE)  && !rst;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Self-checking bench for ldpc_iter_ctrl: scenario tasks with a done-time scoreboard
// of expected {success, iter_cnt}; a second instance covers MAX_ITER=1.
module tb_ldpc_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, syn_valid, syn_zero;
  logic       load_en, cnu_en, vnu_en, chk_en, busy, done, success;
  logic [3:0] iter_cnt;

  logic       start1, syn_valid1, syn_zero1, abort1;
  logic       load_en1, cnu_en1, vnu_en1, chk_en1, busy1, done1, success1;
  logic [3:0] iter_cnt1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic       succ;
    logic [3:0] iter;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];

  always #5 clk = ~clk;

  ldpc_iter_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .syn_valid(syn_valid), .syn_zero(syn_zero),
    .load_en(load_en), .cnu_en(cnu_en), .vnu_en(vnu_en), .chk_en(chk_en),
    .iter_cnt(iter_cnt), .busy(busy), .done(done), .success(success)
  );

  ldpc_iter_ctrl #(.MAX_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .syn_valid(syn_valid1), .syn_zero(syn_zero1),
    .load_en(load_en1), .cnu_en(cnu_en1), .vnu_en(vnu_en1), .chk_en(chk_en1),
    .iter_cnt(iter_cnt1), .busy(busy1), .done(done1), .success(success1)
  );

  // Done monitors: pop the expected outcome and check exclusivity of strobes.
  exp_t e0, e1;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones({load_en, cnu_en, vnu_en, chk_en, done}) > 1) begin
        failures++;
        $display("[TB] FAIL onehot cyc=%0d got=%b want at most one bit", cyc,
                 {load_en, cnu_en, vnu_en, chk_en, done});
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_done cyc=%0d got=done want=no done", cyc);
        end else begin
          e0 = sb.pop_front();
          if ({success, iter_cnt} !== {e0.succ, e0.iter}) begin
            failures++;
            $display("[TB] FAIL done_result cyc=%0d got succ=%b iter=%0d want succ=%b iter=%0d",
                     cyc, success, iter_cnt, e0.succ, e0.iter);
          end
        end
      end
      if (done1) begin
        checks++;
        if (sb1.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_done1 cyc=%0d got=done want=no done", cyc);
        end else begin
          e1 = sb1.pop_front();
          if ({success1, iter_cnt1} !== {e1.succ, e1.iter}) begin
            failures++;
            $display("[TB] FAIL done1_result cyc=%0d got succ=%b iter=%0d want succ=%b iter=%0d",
                     cyc, success1, iter_cnt1, e1.succ, e1.iter);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [4:0] early_exp(input int n);
    case (n)
      1:       return 5'b10000;
      2, 3:    return 5'b01000;
      4, 5:    return 5'b00100;
      6:       return 5'b00010;
      7:       return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; syn_valid = 1'b0; syn_zero = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; syn_valid1 = 1'b0; syn_zero1 = 1'b0;
    step(); step();
    checks++;
    if ({load_en, cnu_en, vnu_en, chk_en, busy, done, success, iter_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold got=%b want=0",
               {load_en, cnu_en, vnu_en, chk_en, busy, done, success, iter_cnt});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({load_en, cnu_en, vnu_en, chk_en, busy, done, success, iter_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_idle got=%b want=0",
               {load_en, cnu_en, vnu_en, chk_en, busy, done, success, iter_cnt});
    end
  endtask

  task automatic test_early_converge();
    logic [4:0] want;
    start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b1;
    sb.push_back('{succ: 1'b1, iter: 4'd0});
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 1) start = 1'b0;
      want = early_exp(n);
      checks++;
      if ({load_en, cnu_en, vnu_en, chk_en, done} !== want) begin
        failures++;
        $display("[TB] FAIL early_seq c%0d got=%b want=%b", n,
                 {load_en, cnu_en, vnu_en, chk_en, done}, want);
      end
    end
    step();
    syn_valid = 1'b0; syn_zero = 1'b0;
    checks++;
    if ({busy, done, success, iter_cnt} !== 7'b0010000) begin
      failures++;
      $display("[TB] FAIL early_idle got busy=%b done=%b succ=%b iter=%0d want 0 0 1 0",
               busy, done, success, iter_cnt);
    end
  endtask

  task automatic test_no_converge();
    int done_cyc, chks;
    done_cyc = -1; chks = 0;
    start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b0;
    sb.push_back('{succ: 1'b0, iter: 4'd7});
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 1) start = 1'b0;
      if (chk_en) chks++;
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    syn_valid = 1'b0;
    checks++;
    if (done_cyc != 42) begin
      failures++;
      $display("[TB] FAIL noconv_done_cycle got=%0d want=42", done_cyc);
    end
    checks++;
    if (chks != 8) begin
      failures++;
      $display("[TB] FAIL noconv_checks got=%0d want=8", chks);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL noconv_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_stall();
    int n, pulses;
    syn_valid = 1'b0; syn_zero = 1'b0;
    start = 1'b1;
    sb.push_back('{succ: 1'b1, iter: 4'd3});
    step();
    start = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      n = 0;
      while (!chk_en && n < 50) begin
        step();
        n++;
      end
      checks++;
      if (chk_en !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_timeout iter=%0d got chk_en=%b want=1", k, chk_en);
        break;
      end
      for (int j = 0; j < 4; j++) begin
        step();
        checks++;
        if (chk_en !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stall_hold iter=%0d wait=%0d got chk_en=%b want=1", k, j, chk_en);
        end
      end
      syn_valid = 1'b1;
      syn_zero  = (k == 3);
      step();
      syn_valid = 1'b0; syn_zero = 1'b0;
      checks++;
      if (k < 3) begin
        if ({cnu_en, iter_cnt} !== {1'b1, 4'(k + 1)}) begin
          failures++;
          $display("[TB] FAIL stall_next iter=%0d got cnu=%b iter=%0d want cnu=1 iter=%0d",
                   k, cnu_en, iter_cnt, k + 1);
        end
      end else if (done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_done got=%b want=1", done);
      end
    end
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_single_done got extra=%0d busy=%b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_abort();
    int n, pulses;
    start = 1'b1; syn_valid = 1'b0; syn_zero = 1'b0;
    step();
    start = 1'b0;
    n = 0;
    while (!chk_en && n < 50) begin step(); n++; end
    syn_valid = 1'b1;
    step();
    syn_valid = 1'b0;
    n = 0;
    while (!vnu_en && n < 50) begin step(); n++; end
    step();
    checks++;
    if ({vnu_en, iter_cnt} !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL abort_setup got vnu=%b iter=%0d want vnu=1 iter=1", vnu_en, iter_cnt);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, done, success, iter_cnt} !== 7'b0000001) begin
      failures++;
      $display("[TB] FAIL abort_vnu got busy=%b done=%b succ=%b iter=%0d want 0 0 0 1",
               busy, done, success, iter_cnt);
    end
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL abort_quiet got active_cycles=%0d want=0", pulses);
    end
    // abort together with a converged syndrome
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!chk_en && n < 50) begin step(); n++; end
    abort = 1'b1; syn_valid = 1'b1; syn_zero = 1'b1;
    step();
    abort = 1'b0; syn_valid = 1'b0; syn_zero = 1'b0;
    checks++;
    if ({busy, done, success, iter_cnt} !== 7'b0000000) begin
      failures++;
      $display("[TB] FAIL abort_check got busy=%b done=%b succ=%b iter=%0d want 0 0 0 0",
               busy, done, success, iter_cnt);
    end
    // abort is ignored in IDLE, honoured in LOAD
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (load_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_idle_ignored got load_en=%b want=1", load_en);
    end
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_load got busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n, chks;
    start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b0;
    step();
    start = 1'b0;
    n = 0; chks = 0;
    while (n < 100) begin
      if (chk_en) chks++;
      if (chks == 2 && cnu_en) break;
      step();
      n++;
    end
    checks++;
    if ({cnu_en, iter_cnt} !== 5'b10010) begin
      failures++;
      $display("[TB] FAIL rstmid_setup got cnu=%b iter=%0d want cnu=1 iter=2", cnu_en, iter_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({load_en, cnu_en, vnu_en, chk_en, busy, done} !== 6'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_gate got=%b want=0",
               {load_en, cnu_en, vnu_en, chk_en, busy, done});
    end
    step();
    rst = 1'b0; syn_valid = 1'b0;
    checks++;
    if ({load_en, cnu_en, vnu_en, chk_en, busy, done, success, iter_cnt} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_idle got=%b want=0",
               {load_en, cnu_en, vnu_en, chk_en, busy, done, success, iter_cnt});
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_stay got busy=%b want=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int loads, n;
    start = 1'b1; syn_valid = 1'b1; syn_zero = 1'b1;
    sb.push_back('{succ: 1'b1, iter: 4'd0});
    loads = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (load_en) loads++;
    end
    checks++;
    if (loads != 1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_held got loads=%0d busy=%b want loads=1 busy=0", loads, busy);
    end
    sb.push_back('{succ: 1'b1, iter: 4'd0});
    step();
    start = 1'b0;
    checks++;
    if (load_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL restart got load_en=%b want=1", load_en);
    end
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL restart_done_timeout got done=%b want=1", done);
    end
    step();
    syn_valid = 1'b0; syn_zero = 1'b0;
  endtask

  task automatic test_single_iter();
    int done_cyc, chks;
    done_cyc = -1; chks = 0;
    start1 = 1'b1; syn_valid1 = 1'b1; syn_zero1 = 1'b0;
    sb1.push_back('{succ: 1'b0, iter: 4'd0});
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 1) start1 = 1'b0;
      if (chk_en1) chks++;
      if (done1) begin
        done_cyc = n;
        break;
      end
    end
    syn_valid1 = 1'b0;
    checks++;
    if (done_cyc != 7 || chks != 1) begin
      failures++;
      $display("[TB] FAIL single_iter got done_cyc=%0d checks=%0d want done_cyc=7 checks=1",
               done_cyc, chks);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_early_converge();
    test_no_converge();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_single_iter();
    step();
    checks++;
    if (sb.size() != 0 || sb1.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got pending=%0d/%0d want 0/0", sb.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ldpc_iter_ctrl.md
LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

Interface
REQ-001 SHALL have parameter MAX_ITER, default 8, meaning the maximum number of decode iterations (legal range 1..2^ITER_W).
REQ-002 SHALL have parameter ITER_W, default 4, meaning the width of the iteration counter.
REQ-003 SHALL have parameter CNU_CYC, default 2, meaning the cycles per check-node phase (>=1).
REQ-004 SHALL have parameter VNU_CYC, default 2, meaning the cycles per variable-node phase (>=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: begin decoding a loaded codeword (channel LLRs L valid).
REQ-008 SHALL have port abort, input, 1 bit: terminate the decode immediately.
REQ-009 SHALL have port syn_valid, input, 1 bit: the parity-check result is valid this cycle.
REQ-010 SHALL have port syn_zero, input, 1 bit: all parity checks satisfied; qualified by syn_valid.
REQ-011 SHALL have port load_en, output, 1 bit: the VNUs seed Q outputs from L.
REQ-012 SHALL have port cnu_en, output, 1 bit: the check-node units compute R from Q.
REQ-013 SHALL have port vnu_en, output, 1 bit: the VNUs compute P = sum(R) + L and Q_i = P - R_i.
REQ-014 SHALL have port chk_en, output, 1 bit: the parity checker evaluates the hard decisions (sign of P).
REQ-015 SHALL have port iter_cnt, output, ITER_W bits: the zero-based index of the current or last iteration.
REQ-016 SHALL have port busy, output, 1 bit: the controller is not IDLE.
REQ-017 SHALL have port done, output, 1 bit: a one-cycle pulse at decode completion.
REQ-018 SHALL have port success, output, 1 bit: the last decode converged; valid from done until the next start.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE, LOAD, CNU, VNU, CHECK and DONE; all enable outputs decode from the registered state only.
REQ-020 SHALL, in IDLE with start=1, go to LOAD; start SHALL be ignored in all other states.
REQ-021 SHALL hold LOAD for exactly 1 cycle with load_en=1, clear iter_cnt to 0 and clear success, then go to CNU.
REQ-022 SHALL hold CNU for exactly CNU_CYC cycles with cnu_en=1, using a phase counter reloaded on entry, then go to VNU.
REQ-023 SHALL hold VNU for exactly VNU_CYC cycles with vnu_en=1, then go to CHECK.
REQ-024 SHALL assert chk_en in CHECK and stay in CHECK until syn_valid=1; the wait is unbounded.
REQ-025 SHALL, in CHECK with syn_valid=1 and syn_zero=1, set success=1 and go to DONE; iter_cnt holds.
REQ-026 SHALL, in CHECK with syn_valid=1, syn_zero=0 and iter_cnt==MAX_ITER-1, go to DONE with success=0; iter_cnt holds.
REQ-027 SHALL, in CHECK with syn_valid=1, syn_zero=0 and iter_cnt<MAX_ITER-1, increment iter_cnt and go to CNU.
REQ-028 SHALL ignore syn_valid and syn_zero outside CHECK.
REQ-029 SHALL assert done=1 for exactly one cycle in DONE, then go to IDLE.
REQ-030 SHALL hold iter_cnt and success in IDLE until the next LOAD.
REQ-031 SHALL, on abort=1 in LOAD, CNU, VNU or CHECK, go to IDLE next cycle with no done pulse, success=0 and iter_cnt held.
REQ-032 SHALL give abort priority over a simultaneous syn_valid.
REQ-033 SHALL ignore abort in IDLE and DONE.
REQ-034 SHALL assert at most one of load_en, cnu_en, vnu_en, chk_en and done in any cycle.
REQ-035 SHALL assert busy=1 in every state except IDLE, including DONE.

Reset
REQ-036 SHALL, on rst=1 at a clock edge, force state=IDLE, iter_cnt=0, success=0 and phase counter=0 from any state, including mid-decode.
REQ-037 SHALL hold all enables, busy and done at 0 while rst=1.
REQ-038 SHALL give rst priority over start and abort.

Verification
REQ-039 SHALL cover early convergence: defaults, start at cycle 0, syn_valid=1 and syn_zero=1 on first CHECK -> LOAD c1, CNU c2-3, VNU c4-5, CHECK c6, done c7, success=1, iter_cnt=0.
REQ-040 SHALL cover non-convergence: syn_valid=1 and syn_zero=0 every CHECK -> 8 iterations of 5 cycles, done at c42, success=0, iter_cnt=7.
REQ-041 SHALL cover convergence with a check stall: syn_zero=1 on iteration 3, syn_valid delayed 4 cycles in each CHECK -> chk_en held during the wait, iter_cnt=3, success=1, single done pulse.
REQ-042 SHALL cover abort: abort=1 on the 2nd VNU cycle of iteration 1 -> IDLE next cycle, busy=0, no done, iter_cnt=1; abort=1 together with syn_valid in CHECK -> IDLE, no done.
REQ-043 SHALL cover reset and start-ignore: rst=1 during CNU of iteration 2 -> IDLE, iter_cnt=0, all outputs 0 next cycle; start held high through a full decode -> no restart until IDLE is re-entered.
REQ-044 SHALL cover the single-iteration boundary: MAX_ITER=1, syn_zero=0 on first CHECK -> done, success=0, iter_cnt=0.
